// File: rtl/cart_mem_arbiter.sv
// cart_mem_arbiter
//
// Memory-side responder for the cartridge mappers. Takes the translated
// 22-bit PRG and CHR addresses (with their mapper "allow" qualifiers),
// arbitrates them onto one variable-latency external memory port and hands
// read data back with a one-cycle completion pulse per client.
//
// Build option:
//   CART_MEM_TIMEOUT_EN  when defined, an access left unacknowledged for
//                        TIMEOUT cycles in ISSUE is aborted (read returns
//                        8'hFF, sticky `timeout` set). When undefined, ISSUE
//                        waits indefinitely and `timeout` is tied to 0.
//
// Parameters:
//   TIMEOUT    abort threshold in cycles (1..65535), timeout build only.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   prg_req/addr/we/wdata/allow PRG access strobe and its qualifiers
//   prg_rdata, prg_done        PRG read data (held) and completion pulse
//   prg_busy                   PRG access accepted, not yet completed
//   chr_*                      same set for the CHR side
//   mem_req/addr/we/wdata      external memory request, held until ack
//   mem_rdata, mem_ack         external memory read data and acknowledge
//   overflow                   sticky: a request arrived while its port was busy
//   timeout                    sticky: an access was aborted by the timer
//
// Arbiter states:
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | no access in flight; grant a pending slot at the next edge
//   S_ISSUE  | mem_req held high for the granted slot, waiting for mem_ack
//   S_LOCAL  | granted slot is disallowed; complete locally, no memory cycle

module cart_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        prg_req,
  input  logic [21:0] prg_addr,
  input  logic        prg_we,
  input  logic [7:0]  prg_wdata,
  input  logic        prg_allow,
  output logic [7:0]  prg_rdata,
  output logic        prg_done,
  output logic        prg_busy,

  input  logic        chr_req,
  input  logic [21:0] chr_addr,
  input  logic        chr_we,
  input  logic [7:0]  chr_wdata,
  input  logic        chr_allow,
  output logic [7:0]  chr_rdata,
  output logic        chr_done,
  output logic        chr_busy,

  output logic        mem_req,
  output logic [21:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,

  output logic        overflow,
  output logic        timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_LOCAL = 2'd2;

  localparam logic [7:0] OPEN_BUS = 8'hFF;

  logic [1:0]  state;

  // One-entry slots; contents are only meaningful while the port is busy.
  logic [21:0] prg_addr_q;
  logic        prg_we_q;
  logic [7:0]  prg_wdata_q;
  logic        prg_allow_q;

  logic [21:0] chr_addr_q;
  logic        chr_we_q;
  logic [7:0]  chr_wdata_q;
  logic        chr_allow_q;

  logic        gnt_chr;    // port owning the current ISSUE/LOCAL access
  logic        last_chr;   // winner of the most recent tie

  logic        prg_accept;
  logic        chr_accept;
  logic        any_pending;
  logic        grant_chr;
  logic        grant_allow;
  logic [21:0] grant_addr;
  logic        grant_we;
  logic [7:0]  grant_wdata;

  logic        issue_ack;
  logic        issue_abort;
  logic        finish;
  logic        finish_read;
  logic [7:0]  finish_rdata;
  logic        prg_finish;
  logic        chr_finish;

  // ---------------------------------------------------------------------
  // Acceptance. A busy port cannot take a new request; busy is already low
  // in the done cycle, so back-to-back requests there are accepted.
  // ---------------------------------------------------------------------
  assign prg_accept = prg_req & ~prg_busy;
  assign chr_accept = chr_req & ~chr_busy;

  // ---------------------------------------------------------------------
  // Grant selection. In IDLE a busy flag always means "pending": the
  // completing edge clears busy and returns the FSM to IDLE together.
  // On a tie the port that did not win the previous tie goes first;
  // an uncontested grant does not move last_chr.
  // ---------------------------------------------------------------------
  assign any_pending = prg_busy | chr_busy;
  assign grant_chr   = chr_busy & (~prg_busy | ~last_chr);

  always_comb begin
    grant_addr  = prg_addr_q;
    grant_we    = prg_we_q;
    grant_wdata = prg_wdata_q;
    grant_allow = prg_allow_q;
    if (grant_chr) begin
      grant_addr  = chr_addr_q;
      grant_we    = chr_we_q;
      grant_wdata = chr_wdata_q;
      grant_allow = chr_allow_q;
    end
  end

  // ---------------------------------------------------------------------
  // Completion. An ack and a timer expiry on the same edge count as an ack.
  // ---------------------------------------------------------------------
  assign issue_ack    = (state == S_ISSUE) & mem_ack;
  assign finish       = issue_ack | issue_abort | (state == S_LOCAL);
  assign finish_read  = gnt_chr ? ~chr_we_q : ~prg_we_q;
  assign finish_rdata = issue_ack ? mem_rdata : OPEN_BUS;
  assign prg_finish   = finish & ~gnt_chr;
  assign chr_finish   = finish &  gnt_chr;

  // ---------------------------------------------------------------------
  // Slots and busy flags
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      prg_busy    <= 1'b0;
      prg_addr_q  <= '0;
      prg_we_q    <= 1'b0;
      prg_wdata_q <= '0;
      prg_allow_q <= 1'b0;
    end else if (prg_accept) begin
      prg_busy    <= 1'b1;
      prg_addr_q  <= prg_addr;
      prg_we_q    <= prg_we;
      prg_wdata_q <= prg_wdata;
      prg_allow_q <= prg_allow;
    end else if (prg_finish) begin
      prg_busy    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chr_busy    <= 1'b0;
      chr_addr_q  <= '0;
      chr_we_q    <= 1'b0;
      chr_wdata_q <= '0;
      chr_allow_q <= 1'b0;
    end else if (chr_accept) begin
      chr_busy    <= 1'b1;
      chr_addr_q  <= chr_addr;
      chr_we_q    <= chr_we;
      chr_wdata_q <= chr_wdata;
      chr_allow_q <= chr_allow;
    end else if (chr_finish) begin
      chr_busy    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if ((prg_req & prg_busy) | (chr_req & chr_busy)) begin
      overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Completion outputs. rdata only changes on a read completion, so it
  // holds its value between completions and across writes.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      prg_done  <= 1'b0;
      chr_done  <= 1'b0;
      prg_rdata <= 8'h00;
      chr_rdata <= 8'h00;
    end else begin
      prg_done <= prg_finish;
      chr_done <= chr_finish;
      if (prg_finish && finish_read) begin
        prg_rdata <= finish_rdata;
      end
      if (chr_finish && finish_read) begin
        chr_rdata <= finish_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Arbiter FSM and memory port
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      gnt_chr   <= 1'b0;
      last_chr  <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_pending) begin
            gnt_chr <= grant_chr;
            if (prg_busy && chr_busy) begin
              last_chr <= grant_chr;
            end
            if (grant_allow) begin
              state     <= S_ISSUE;
              mem_req   <= 1'b1;
              mem_addr  <= grant_addr;
              mem_we    <= grant_we;
              mem_wdata <= grant_wdata;
            end else begin
              state <= S_LOCAL;
            end
          end
        end

        S_ISSUE: begin
          if (finish) begin
            state   <= S_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end

        S_LOCAL: begin
          state <= S_IDLE;
        end

        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Optional access timer: a down-counter loaded on grant, aborting when
  // it reaches its terminal count. Loading TIMEOUT and aborting at 1 puts
  // the abort on the same edge an ack with k = TIMEOUT would land.
  // ---------------------------------------------------------------------
  localparam bit TIMEOUT_LEGAL = (TIMEOUT >= 1) && (TIMEOUT <= 65535);

`ifdef CART_MEM_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LD = TIMEOUT_LEGAL ? 16'(TIMEOUT) :
                                       (TIMEOUT == 0) ? 16'd1 : 16'hFFFF;

  logic [15:0] to_cnt;
  logic        timeout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state == S_IDLE && any_pending && grant_allow) begin
      to_cnt <= TIMEOUT_LD;
    end else if (state == S_ISSUE && to_cnt != 16'd0) begin
      to_cnt <= to_cnt - 16'd1;
    end
  end

  assign issue_abort = (state == S_ISSUE) & ~mem_ack & (to_cnt == 16'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else if (issue_abort) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign issue_abort = 1'b0;
  // Always 0 without the timer; the term keeps TIMEOUT referenced.
  assign timeout     = 1'b0 & TIMEOUT_LEGAL;
`endif

endmodule

// File: tb/tb_cart_mem_arbiter.sv
module tb_cart_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        prg_req, prg_we, prg_allow;
  logic [21:0] prg_addr;
  logic [7:0]  prg_wdata, prg_rdata;
  logic        prg_done, prg_busy;
  logic        chr_req, chr_we, chr_allow;
  logic [21:0] chr_addr;
  logic [7:0]  chr_wdata, chr_rdata;
  logic        chr_done, chr_busy;
  logic        mem_req, mem_we, mem_ack;
  logic [21:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        overflow, timeout;

  int total = 0;
  int bad   = 0;

  cart_mem_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .prg_req(prg_req), .prg_addr(prg_addr), .prg_we(prg_we),
    .prg_wdata(prg_wdata), .prg_allow(prg_allow), .prg_rdata(prg_rdata),
    .prg_done(prg_done), .prg_busy(prg_busy),
    .chr_req(chr_req), .chr_addr(chr_addr), .chr_we(chr_we),
    .chr_wdata(chr_wdata), .chr_allow(chr_allow), .chr_rdata(chr_rdata),
    .chr_done(chr_done), .chr_busy(chr_busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .overflow(overflow), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    total++; if (prg_done !== 1'b0) begin bad++; $display("FAIL reset_prg_done got=%b exp=0", prg_done); end
    total++; if (chr_done !== 1'b0) begin bad++; $display("FAIL reset_chr_done got=%b exp=0", chr_done); end
    total++; if (prg_busy !== 1'b0) begin bad++; $display("FAIL reset_prg_busy got=%b exp=0", prg_busy); end
    total++; if (chr_busy !== 1'b0) begin bad++; $display("FAIL reset_chr_busy got=%b exp=0", chr_busy); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    total++; if (mem_addr !== 22'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    total++; if (mem_wdata !== 8'h00) begin bad++; $display("FAIL reset_mem_wdata got=%h exp=00", mem_wdata); end
    total++; if (prg_rdata !== 8'h00) begin bad++; $display("FAIL reset_prg_rdata got=%h exp=00", prg_rdata); end
    total++; if (chr_rdata !== 8'h00) begin bad++; $display("FAIL reset_chr_rdata got=%h exp=00", chr_rdata); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    reset = 1'b0;
  endtask

  task automatic test_prg_read;
    prg_addr = 22'h00_8123; prg_we = 1'b0; prg_allow = 1'b1; prg_req = 1'b1;
    tick;                                   // E0
    prg_req = 1'b0;
    total++; if (prg_busy !== 1'b1) begin bad++; $display("FAIL rd_busy got=%b exp=1", prg_busy); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rd_req_e0 got=%b exp=0", mem_req); end
    tick;                                   // E1
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rd_req_e1 got=%b exp=1", mem_req); end
    total++; if (mem_addr !== 22'h00_8123) begin bad++; $display("FAIL rd_addr got=%h exp=008123", mem_addr); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rd_we got=%b exp=0", mem_we); end
    tick; tick;                             // E2, E3
    total++; if (prg_done !== 1'b0) begin bad++; $display("FAIL rd_done_early got=%b exp=0", prg_done); end
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rd_req_held got=%b exp=1", mem_req); end
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    tick;                                   // E4
    mem_ack = 1'b0; mem_rdata = 8'h00;
    total++; if (prg_done !== 1'b1) begin bad++; $display("FAIL rd_done got=%b exp=1", prg_done); end
    total++; if (prg_rdata !== 8'h5A) begin bad++; $display("FAIL rd_data got=%h exp=5a", prg_rdata); end
    total++; if (prg_busy !== 1'b0) begin bad++; $display("FAIL rd_busy_clr got=%b exp=0", prg_busy); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rd_req_drop got=%b exp=0", mem_req); end
    tick;
    total++; if (prg_done !== 1'b0) begin bad++; $display("FAIL rd_done_pulse got=%b exp=0", prg_done); end
    total++; if (prg_rdata !== 8'h5A) begin bad++; $display("FAIL rd_data_hold got=%h exp=5a", prg_rdata); end
  endtask

  task automatic test_write;
    prg_addr = 22'h3F_FFFF; prg_we = 1'b1; prg_wdata = 8'hA5; prg_allow = 1'b1; prg_req = 1'b1;
    tick;
    prg_req = 1'b0; prg_we = 1'b0;
    tick;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL wr_req got=%b exp=1", mem_req); end
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL wr_we got=%b exp=1", mem_we); end
    total++; if (mem_wdata !== 8'hA5) begin bad++; $display("FAIL wr_wdata got=%h exp=a5", mem_wdata); end
    total++; if (mem_addr !== 22'h3F_FFFF) begin bad++; $display("FAIL wr_addr got=%h exp=3fffff", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 8'h11;
    tick;
    mem_ack = 1'b0; mem_rdata = 8'h00;
    total++; if (prg_done !== 1'b1) begin bad++; $display("FAIL wr_done got=%b exp=1", prg_done); end
    total++; if (prg_rdata !== 8'h5A) begin bad++; $display("FAIL wr_rdata_kept got=%h exp=5a", prg_rdata); end
    tick;
  endtask

  task automatic test_tie_break;
    reset = 1'b1; tick; reset = 1'b0;
    prg_addr = 22'h01_0000; prg_we = 1'b0; prg_allow = 1'b1; prg_req = 1'b1;
    chr_addr = 22'h20_0000; chr_we = 1'b0; chr_allow = 1'b1; chr_req = 1'b1;
    tick;
    prg_req = 1'b0; chr_req = 1'b0;
    tick;
    total++; if (mem_addr !== 22'h20_0000) begin bad++; $display("FAIL tie1_addr got=%h exp=200000", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 8'hC3;
    tick;
    mem_ack = 1'b0;
    total++; if (chr_done !== 1'b1) begin bad++; $display("FAIL tie1_chr_done got=%b exp=1", chr_done); end
    total++; if (chr_rdata !== 8'hC3) begin bad++; $display("FAIL tie1_chr_rdata got=%h exp=c3", chr_rdata); end
    total++; if (prg_done !== 1'b0) begin bad++; $display("FAIL tie1_prg_done got=%b exp=0", prg_done); end
    tick;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL tie2_req got=%b exp=1", mem_req); end
    total++; if (mem_addr !== 22'h01_0000) begin bad++; $display("FAIL tie2_addr got=%h exp=010000", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 8'h3C;
    tick;
    mem_ack = 1'b0;
    total++; if (prg_done !== 1'b1) begin bad++; $display("FAIL tie2_prg_done got=%b exp=1", prg_done); end
    total++; if (prg_rdata !== 8'h3C) begin bad++; $display("FAIL tie2_prg_rdata got=%h exp=3c", prg_rdata); end
    // Refill both in the prg_done cycle: both accepted, PRG wins this tie.
    prg_addr = 22'h00_0111; prg_req = 1'b1;
    chr_addr = 22'h20_0222; chr_req = 1'b1;
    tick;
    prg_req = 1'b0; chr_req = 1'b0;
    total++; if ({prg_busy, chr_busy} !== 2'b11) begin bad++; $display("FAIL refill_busy got=%b exp=11", {prg_busy, chr_busy}); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL refill_overflow got=%b exp=0", overflow); end
    tick;
    total++; if (mem_addr !== 22'h00_0111) begin bad++; $display("FAIL tie3_addr got=%h exp=000111", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 8'h01;
    tick;
    mem_ack = 1'b0;
    total++; if (prg_rdata !== 8'h01) begin bad++; $display("FAIL tie3_prg_rdata got=%h exp=01", prg_rdata); end
    tick;
    total++; if (mem_addr !== 22'h20_0222) begin bad++; $display("FAIL tie4_addr got=%h exp=200222", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 8'h02;
    tick;
    mem_ack = 1'b0;
    total++; if (chr_done !== 1'b1) begin bad++; $display("FAIL tie4_chr_done got=%b exp=1", chr_done); end
    total++; if (chr_rdata !== 8'h02) begin bad++; $display("FAIL tie4_chr_rdata got=%h exp=02", chr_rdata); end
    tick;
  endtask

  task automatic test_disallowed;
    chr_addr = 22'h12_3456; chr_we = 1'b1; chr_wdata = 8'h77; chr_allow = 1'b0; chr_req = 1'b1;
    tick;
    chr_req = 1'b0; chr_we = 1'b0;
    total++; if (chr_busy !== 1'b1) begin bad++; $display("FAIL dis_busy got=%b exp=1", chr_busy); end
    mem_ack = 1'b1; mem_rdata = 8'hEE;    // stray ack, FSM not in ISSUE
    tick;
    mem_ack = 1'b0;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL dis_req got=%b exp=0", mem_req); end
    total++; if (chr_done !== 1'b0) begin bad++; $display("FAIL dis_done_early got=%b exp=0", chr_done); end
    tick;
    total++; if (chr_done !== 1'b1) begin bad++; $display("FAIL dis_done got=%b exp=1", chr_done); end
    total++; if (chr_rdata !== 8'h02) begin bad++; $display("FAIL dis_rdata_kept got=%h exp=02", chr_rdata); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL dis_req2 got=%b exp=0", mem_req); end
    tick;
    chr_allow = 1'b1;
    prg_addr = 22'h00_0000; prg_we = 1'b0; prg_allow = 1'b0; prg_req = 1'b1;
    tick;
    prg_req = 1'b0;
    tick; tick;
    total++; if (prg_done !== 1'b1) begin bad++; $display("FAIL dis_rd_done got=%b exp=1", prg_done); end
    total++; if (prg_rdata !== 8'hFF) begin bad++; $display("FAIL dis_rd_openbus got=%h exp=ff", prg_rdata); end
    prg_allow = 1'b1;
    tick;
  endtask

  task automatic test_overflow;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_pre got=%b exp=0", overflow); end
    prg_addr = 22'h00_4000; prg_we = 1'b0; prg_allow = 1'b1; prg_req = 1'b1;
    tick;
    prg_addr = 22'h00_4444;               // still requesting while busy
    tick;
    prg_req = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    total++; if (mem_addr !== 22'h00_4000) begin bad++; $display("FAIL ovf_addr got=%h exp=004000", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 8'h99;
    tick;
    mem_ack = 1'b0;
    total++; if (prg_rdata !== 8'h99) begin bad++; $display("FAIL ovf_rdata got=%h exp=99", prg_rdata); end
    tick; tick;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL ovf_dropped_req got=%b exp=0", mem_req); end
    total++; if (prg_busy !== 1'b0) begin bad++; $display("FAIL ovf_dropped_busy got=%b exp=0", prg_busy); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_reset_mid;
    prg_addr = 22'h00_ABCD; prg_we = 1'b0; prg_allow = 1'b1; prg_req = 1'b1;
    tick;
    prg_req = 1'b0;
    tick;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rst_mid_req got=%b exp=1", mem_req); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mid_req_drop got=%b exp=0", mem_req); end
    total++; if (prg_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", prg_busy); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_mid_overflow got=%b exp=0", overflow); end
    tick;
    mem_ack = 1'b1; mem_rdata = 8'h77;     // late ack
    tick;
    mem_ack = 1'b0;
    total++; if (prg_done !== 1'b0) begin bad++; $display("FAIL rst_mid_done got=%b exp=0", prg_done); end
    total++; if (prg_rdata !== 8'h00) begin bad++; $display("FAIL rst_mid_rdata got=%h exp=00", prg_rdata); end
    tick;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mid_idle got=%b exp=0", mem_req); end
    prg_addr = 22'h00_BEEF; prg_req = 1'b1;
    tick;
    prg_req = 1'b0;
    tick;
    total++; if (mem_addr !== 22'h00_BEEF) begin bad++; $display("FAIL rst_mid_next_addr got=%h exp=00beef", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 8'h42;
    tick;
    mem_ack = 1'b0;
    total++; if (prg_rdata !== 8'h42) begin bad++; $display("FAIL rst_mid_next_rdata got=%h exp=42", prg_rdata); end
    tick;
  endtask

  task automatic test_timeout;
    prg_addr = 22'h00_1000; prg_we = 1'b0; prg_allow = 1'b1; prg_req = 1'b1;
    tick;
    prg_req = 1'b0;
    tick;                                   // E1: ISSUE entered
`ifdef CART_MEM_TIMEOUT_EN
    repeat (7) tick;                        // E8
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL to_req_e8 got=%b exp=1", mem_req); end
    total++; if (prg_done !== 1'b0) begin bad++; $display("FAIL to_done_e8 got=%b exp=0", prg_done); end
    tick;                                   // E9: abort
    total++; if (prg_done !== 1'b1) begin bad++; $display("FAIL to_done got=%b exp=1", prg_done); end
    total++; if (prg_rdata !== 8'hFF) begin bad++; $display("FAIL to_rdata got=%h exp=ff", prg_rdata); end
    total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_flag got=%b exp=1", timeout); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL to_req_drop got=%b exp=0", mem_req); end
    tick;
`else
    begin
      bit dropped = 1'b0;
      for (int i = 0; i < 300; i++) begin
        tick;
        if (mem_req !== 1'b1 || prg_done !== 1'b0) dropped = 1'b1;
      end
      total++; if (dropped !== 1'b0) begin bad++; $display("FAIL nto_held got=%b exp=0", dropped); end
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL nto_flag got=%b exp=0", timeout); end
      total++; if (prg_busy !== 1'b1) begin bad++; $display("FAIL nto_busy got=%b exp=1", prg_busy); end
    end
    mem_ack = 1'b1; mem_rdata = 8'h6B;
    tick;
    mem_ack = 1'b0;
    total++; if (prg_done !== 1'b1) begin bad++; $display("FAIL nto_done got=%b exp=1", prg_done); end
    total++; if (prg_rdata !== 8'h6B) begin bad++; $display("FAIL nto_rdata got=%h exp=6b", prg_rdata); end
    tick;
`endif
  endtask

  initial begin
    reset = 1'b1;
    prg_req = 1'b0; prg_addr = '0; prg_we = 1'b0; prg_wdata = '0; prg_allow = 1'b0;
    chr_req = 1'b0; chr_addr = '0; chr_we = 1'b0; chr_wdata = '0; chr_allow = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    test_reset;
    test_prg_read;
    test_write;
    test_tie_break;
    test_disallowed;
    test_overflow;
    test_reset_mid;
    test_timeout;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
